ones_pattern_gen: RTL and testbench

Sequential generator that is the inverse of the count-ones datapath: given a target population count `k`, it enumerates every `DATA_WIDTH`-bit word containing exactly `k` ones, in ascending numeric order, one word per accepted handshake. It sits upstream of the count-ones block as an exhaustive stimulus and pattern source. It streams words over a valid/ready interface and flags the final word of each sequence.

---
 rtl/ones_pattern_gen.sv | 140 ++++++++++++++
 tb/tb_ones_pattern_gen.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ones_pattern_gen.sv
// Enumerates every DATA_WIDTH-bit word with exactly k ones, ascending, over valid/ready.
// Define ONES_GEN_SELFCHECK_EN to build the popcount/ordering checker behind chk_err.
module ones_pattern_gen #(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [$clog2(DATA_WIDTH):0]   k_in,
    output logic                          busy,
    output logic [DATA_WIDTH-1:0]         dout,
    output logic                          dout_valid,
    input  logic                          dout_ready,
    output logic                          dout_last,
    output logic                          k_err,
    output logic                          chk_err
);

    localparam int unsigned KW = $clog2(DATA_WIDTH) + 1;
    localparam logic [DATA_WIDTH-1:0] One = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e                state_q, state_d;
    logic [KW-1:0]         k_q, k_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  valid_q, valid_d;
    logic                  k_err_q, k_err_d;

    logic [DATA_WIDTH-1:0] first_pat, last_pat, lowest, ripple, next_pat;
    logic [KW-1:0]         tz;
    logic                  xfer, k_bad, last_word;

    always_comb begin
        first_pat = '0;
        last_pat  = '0;
        for (int i = 0; i < int'(DATA_WIDTH); i++) begin
            first_pat[i] = (i < int'(k_in));
            last_pat[i]  = (i >= int'(DATA_WIDTH) - int'(k_q));
        end
    end

    // Trailing-zero count stands in for the division by the lowest set bit.
    always_comb begin
        tz = '0;
        for (int i = int'(DATA_WIDTH) - 1; i >= 0; i--) begin
            if (dout_q[i]) tz = KW'(i);
        end
    end

    assign lowest    = dout_q & (~dout_q + One);
    assign ripple    = dout_q + lowest;
    assign next_pat  = ripple | (((ripple ^ dout_q) >> 2) >> tz);
    assign last_word = valid_q && (dout_q == last_pat);
    assign xfer      = valid_q && dout_ready;
    assign k_bad     = int'(k_in) > int'(DATA_WIDTH);

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        dout_d  = dout_q;
        valid_d = valid_q;
        k_err_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (k_bad) begin
                        k_err_d = 1'b1;
                    end else begin
                        k_d     = k_in;
                        dout_d  = first_pat;
                        valid_d = 1'b1;
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                if (xfer) begin
                    if (last_word) begin
                        valid_d = 1'b0;
                        state_d = StIdle;
                    end else begin
                        dout_d = next_pat;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            k_q     <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            k_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            k_err_q <= k_err_d;
        end
    end

    assign busy       = (state_q == StRun);
    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign dout_last  = last_word;
    assign k_err      = k_err_q;

`ifdef ONES_GEN_SELFCHECK_EN
    logic [KW-1:0] pop;
    logic          chk_bad;
    logic          chk_err_q;

    always_comb begin
        pop = '0;
        for (int i = 0; i < int'(DATA_WIDTH); i++) begin
            pop = pop + KW'(dout_q[i]);
        end
        chk_bad = xfer && (state_q == StRun) &&
                  ((pop != k_q) || (!last_word && (next_pat <= dout_q)));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chk_err_q <= 1'b0;
        end else begin
            chk_err_q <= chk_err_q | chk_bad;
        end
    end

    assign chk_err = chk_err_q;
`else
    assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_ones_pattern_gen.sv
// Directed bench for ones_pattern_gen; expected words come from a brute-force popcount model.
module tb_ones_pattern_gen;

    logic        clk;
    logic        reset;
    logic        start;
    logic [4:0]  k_in;
    logic        busy;
    logic [15:0] dout;
    logic        dout_valid;
    logic        dout_ready;
    logic        dout_last;
    logic        k_err;
    logic        chk_err;

    int          n_tests;
    int          n_fail;
    logic [15:0] exp_q[$];

    ones_pattern_gen #(.DATA_WIDTH(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .k_in       (k_in),
        .busy       (busy),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_last  (dout_last),
        .k_err      (k_err),
        .chk_err    (chk_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("%s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Push every 16-bit word with k ones in ascending order, then issue start.
    task automatic start_k(input int k);
        for (int v = 0; v < 65536; v++) begin
            if ($countones(v[15:0]) == k) exp_q.push_back(v[15:0]);
        end
        dout_ready = 1'b0;
        start      = 1'b1;
        k_in       = 5'(k);
        @(negedge clk);
        start = 1'b0;
        check("first_valid", {31'b0, dout_valid}, 1);
        check("busy_run", {31'b0, busy}, 1);
    endtask

    // Consume words with ready high; optionally stall 3 cycles on stall_word.
    task automatic drain(input int stall_word, input int max_words,
                         output int n_words, output logic [15:0] last_word);
        int          guard;
        bit          stalled;
        logic [15:0] e;
        guard      = 0;
        stalled    = 0;
        n_words    = 0;
        last_word  = '0;
        dout_ready = 1'b1;
        while (exp_q.size() > 0 && n_words < max_words && guard < 70000) begin
            if (!stalled && dout_valid && int'(dout) == stall_word) begin
                stalled    = 1;
                dout_ready = 1'b0;
                start      = 1'b1;
                k_in       = 5'd1;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    start = 1'b0;
                    check("bp_hold", {16'b0, dout}, stall_word);
                    check("bp_valid", {31'b0, dout_valid}, 1);
                    check("bp_busy", {31'b0, busy}, 1);
                end
                dout_ready = 1'b1;
            end
            if (dout_valid) begin
                e         = exp_q.pop_front();
                last_word = e;
                n_words++;
                check("word", {16'b0, dout}, {16'b0, e});
                check("last", {31'b0, dout_last}, (exp_q.size() == 0) ? 1 : 0);
            end else begin
                check("stream_valid", {31'b0, dout_valid}, 1);
            end
            @(negedge clk);
            guard++;
        end
        if (n_words < max_words) check("drain_left", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic after_checks(input logic [15:0] last_word);
        check("busy_after", {31'b0, busy}, 0);
        check("valid_after", {31'b0, dout_valid}, 0);
        check("last_after", {31'b0, dout_last}, 0);
        check("dout_keep", {16'b0, dout}, {16'b0, last_word});
        check("chk_err", {31'b0, chk_err}, 0);
    endtask

    initial begin
        int          n;
        logic [15:0] lw;
        n_tests    = 0;
        n_fail     = 0;
        reset      = 1'b1;
        start      = 1'b0;
        k_in       = '0;
        dout_ready = 1'b0;

        @(negedge clk);
        check("rst_dout", {16'b0, dout}, 0);
        check("rst_valid", {31'b0, dout_valid}, 0);
        check("rst_last", {31'b0, dout_last}, 0);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_kerr", {31'b0, k_err}, 0);
        check("rst_chk", {31'b0, chk_err}, 0);
        reset = 1'b0;
        @(negedge clk);

        // k=2 full run at full throughput
        start_k(2);
        drain(-1, 1000000, n, lw);
        check("count_k2", n, 120);
        check("lastword_k2", {16'b0, lw}, 32'h0000_C000);
        after_checks(16'hC000);

        // single-word edge cases
        start_k(0);
        drain(-1, 1000000, n, lw);
        check("count_k0", n, 1);
        after_checks(16'h0000);
        start_k(16);
        drain(-1, 1000000, n, lw);
        check("count_k16", n, 1);
        after_checks(16'hFFFF);

        // out-of-range k
        start = 1'b1;
        k_in  = 5'd17;
        @(negedge clk);
        start = 1'b0;
        check("kerr_pulse", {31'b0, k_err}, 1);
        check("kerr_valid", {31'b0, dout_valid}, 0);
        check("kerr_busy", {31'b0, busy}, 0);
        @(negedge clk);
        check("kerr_clear", {31'b0, k_err}, 0);
        check("kerr_valid2", {31'b0, dout_valid}, 0);
        check("kerr_busy2", {31'b0, busy}, 0);

        // backpressure on 0x000B with a start pulse in RUN
        start_k(3);
        drain(32'h000B, 1000000, n, lw);
        check("count_k3", n, 560);
        after_checks(16'hE000);

        // asynchronous reset mid-run
        start_k(4);
        drain(-1, 10, n, lw);
        check("count_pre_rst", n, 10);
        reset = 1'b1;
        #1;
        check("arst_dout", {16'b0, dout}, 0);
        check("arst_valid", {31'b0, dout_valid}, 0);
        check("arst_last", {31'b0, dout_last}, 0);
        check("arst_busy", {31'b0, busy}, 0);
        check("arst_kerr", {31'b0, k_err}, 0);
        check("arst_chk", {31'b0, chk_err}, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        start_k(1);
        drain(-1, 1000000, n, lw);
        check("count_k1", n, 16);
        after_checks(16'h8000);

`ifdef ONES_GEN_SELFCHECK_EN
        for (int k = 0; k <= 16; k++) begin
            start_k(k);
            drain(-1, 1000000, n, lw);
            after_checks(lw);
        end
`else
        start_k(15);
        drain(-1, 1000000, n, lw);
        check("count_k15", n, 16);
        after_checks(16'hFFFE);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
